// File: rtl/ml_dense_core_pkg.sv
// rtl/ml_dense_core_pkg.sv - FSM state encodings, activation bounds and accumulator sizing for ml_dense_core
package ml_dense_core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MAC  = 3'd2,
        ST_ACT  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int RELU_MIN = 0;
    localparam int RELU_MAX = 255;
    localparam int SAT_MIN  = -128;
    localparam int SAT_MAX  = 127;

    // Wide enough for the worst-case sum of products plus bias, so it never wraps.
    function automatic int acc_width(input int data_w, input int inputs, input int bias_w);
        int w;
        w = 2 * data_w + $clog2(inputs) + 2;
        return (w > bias_w + 1) ? w : bias_w + 1;
    endfunction

endpackage

// File: rtl/ml_mac.sv
// rtl/ml_mac.sv - signed multiplier plus accumulator register with bias preload
module ml_mac
    import ml_dense_core_pkg::*;
#(
    parameter int pDATA_W = 8,
    parameter int pBIAS_W = 16,
    parameter int pACC_W  = 20
) (
    input  logic               crypto_clk,
    input  logic               resetn,
    input  logic               load_bias,
    input  logic               accumulate,
    input  logic [pBIAS_W-1:0] bias_value,
    input  logic [pDATA_W-1:0] a,
    input  logic [pDATA_W-1:0] b,
    output logic [pACC_W-1:0]  acc
);

    logic signed [2*pDATA_W-1:0] product;

    assign product = signed'(a) * signed'(b);

    always_ff @(posedge crypto_clk) begin
        if (!resetn) begin
            acc <= '0;
        end else if (load_bias) begin
            acc <= {{(pACC_W-pBIAS_W){bias_value[pBIAS_W-1]}}, bias_value};
        end else if (accumulate) begin
            acc <= acc + {{(pACC_W-2*pDATA_W){product[2*pDATA_W-1]}}, product};
        end
    end

endmodule

// File: rtl/ml_dense_core.sv
// rtl/ml_dense_core.sv - sequential dense layer, one MAC per clock; ML_RELU_EN selects ReLU instead of signed saturation
module ml_dense_core
    import ml_dense_core_pkg::*;
#(
    parameter int pINPUTS  = 4,
    parameter int pNEURONS = 4,
    parameter int pDATA_W  = 8,
    parameter int pBIAS_W  = 16,
    parameter int pSHIFT   = 0
) (
    input  logic                                crypto_clk,
    input  logic                                resetn,
    input  logic                                start,
    input  logic [pINPUTS*pDATA_W-1:0]          inputs,
    input  logic [pNEURONS*pINPUTS*pDATA_W-1:0] weights,
    input  logic [pNEURONS*pBIAS_W-1:0]         bias,
    output logic [pNEURONS*8-1:0]               result,
    output logic                                busy,
    output logic                                done,
    output logic                                trigger
);

    localparam int ACC_W = acc_width(pDATA_W, pINPUTS, pBIAS_W);
    localparam int J_W   = (pINPUTS > 1) ? $clog2(pINPUTS) : 1;
    localparam int I_W   = (pNEURONS > 1) ? $clog2(pNEURONS) : 1;
    localparam logic [J_W-1:0] J_LAST = J_W'(pINPUTS - 1);
    localparam logic [I_W-1:0] I_LAST = I_W'(pNEURONS - 1);
`ifdef ML_RELU_EN
    localparam logic signed [ACC_W-1:0] ACT_LO = ACC_W'(RELU_MIN);
    localparam logic signed [ACC_W-1:0] ACT_HI = ACC_W'(RELU_MAX);
`else
    localparam logic signed [ACC_W-1:0] ACT_LO = ACC_W'(SAT_MIN);
    localparam logic signed [ACC_W-1:0] ACT_HI = ACC_W'(SAT_MAX);
`endif

    state_t                              state;
    logic [I_W-1:0]                      i;
    logic [I_W-1:0]                      i_next;
    logic [J_W-1:0]                      j;
    logic [pINPUTS*pDATA_W-1:0]          x_snap;
    logic [pNEURONS*pINPUTS*pDATA_W-1:0] w_snap;
    logic [pNEURONS*pBIAS_W-1:0]         b_snap;
    logic [ACC_W-1:0]                    acc;
    logic signed [ACC_W-1:0]             shifted;
    logic [7:0]                          y;
    logic                                load_bias;
    logic                                accumulate;
    logic [pBIAS_W-1:0]                  bias_sel;
    logic [pDATA_W-1:0]                  x_cur;
    logic [pDATA_W-1:0]                  w_cur;

    assign i_next = i + 1'b1;

    // LOAD preloads b_0 straight from the port, the same value being snapshotted.
    always_comb begin
        load_bias  = (state == ST_LOAD) || ((state == ST_ACT) && (i != I_LAST));
        accumulate = (state == ST_MAC);
        bias_sel   = (state == ST_LOAD) ? bias[0 +: pBIAS_W]
                                        : b_snap[int'(i_next)*pBIAS_W +: pBIAS_W];
        x_cur      = x_snap[int'(j)*pDATA_W +: pDATA_W];
        w_cur      = w_snap[(int'(i)*pINPUTS + int'(j))*pDATA_W +: pDATA_W];
    end

    ml_mac #(
        .pDATA_W (pDATA_W),
        .pBIAS_W (pBIAS_W),
        .pACC_W  (ACC_W)
    ) u_mac (
        .crypto_clk (crypto_clk),
        .resetn     (resetn),
        .load_bias  (load_bias),
        .accumulate (accumulate),
        .bias_value (bias_sel),
        .a          (x_cur),
        .b          (w_cur),
        .acc        (acc)
    );

    assign shifted = signed'(acc) >>> pSHIFT;

    always_comb begin
        if (shifted < ACT_LO) begin
            y = ACT_LO[7:0];
        end else if (shifted > ACT_HI) begin
            y = ACT_HI[7:0];
        end else begin
            y = shifted[7:0];
        end
    end

    always_ff @(posedge crypto_clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            i       <= '0;
            j       <= '0;
            x_snap  <= '0;
            w_snap  <= '0;
            b_snap  <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            trigger <= 1'b0;
        end else begin
            done    <= 1'b0;
            trigger <= busy;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    x_snap <= inputs;
                    w_snap <= weights;
                    b_snap <= bias;
                    i      <= '0;
                    j      <= '0;
                    state  <= ST_MAC;
                end
                ST_MAC: begin
                    if (j == J_LAST) begin
                        state <= ST_ACT;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                ST_ACT: begin
                    result[int'(i)*8 +: 8] <= y;
                    if (i != I_LAST) begin
                        i     <= i_next;
                        j     <= '0;
                        state <= ST_MAC;
                    end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
